// File: rtl/fp_add_arbiter_if.sv
// Request/response, shared-adder command and status bundle for fp_add_arbiter.
interface fp_add_arbiter_if;
  localparam int unsigned DataW  = 32;
  localparam int unsigned OpCntW = 16;

  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [DataW-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic              rsp0_valid, rsp1_valid;
  logic              rsp0_ready, rsp1_ready;
  logic [DataW-1:0]  rsp_result;
  logic              rsp_err;
  logic              add_start;
  logic [DataW-1:0]  add_a, add_b;
  logic              add_done;
  logic [DataW-1:0]  add_result;
  logic              busy;
  logic [OpCntW-1:0] op_count;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready, add_done, add_result,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_err,
    output add_start, add_a, add_b, busy, op_count
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, add_done, add_result,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_err,
    input  add_start, add_a, add_b, busy, op_count
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// Two-requester round-robin arbiter in front of one shared FP adder, with a
// completion timeout that returns a flagged 7FFFFFFF result.
module fp_add_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic             clk,
  input logic             reset,
  fp_add_arbiter_if.slave bus
);
  localparam int unsigned      DataW         = 32;
  localparam int unsigned      OpCntW        = 16;
  localparam int unsigned      CntW          = 8;
  localparam logic [DataW-1:0] TimeoutResult = 32'h7FFF_FFFF;
  localparam logic [CntW-1:0]  LastWait      = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateE;

  stateE             state, stateNext;
  logic              owner, ownerNext;
  logic              lastGrant, lastGrantNext;
  logic [CntW-1:0]   waitCnt, waitCntNext;
  logic              addStart, addStartNext;
  logic [DataW-1:0]  addA, addANext;
  logic [DataW-1:0]  addB, addBNext;
  logic [DataW-1:0]  rspResult, rspResultNext;
  logic              rspErr, rspErrNext;
  logic [1:0]        rspValid, rspValidNext;
  logic              busyQ, busyNext;
  logic [OpCntW-1:0] opCount, opCountNext;
  logic              grant0, grant1, ownerReady;

  // On contention the requester that was not served last wins.
  always_comb begin
    grant0 = bus.req0_valid && (!bus.req1_valid || lastGrant);
    grant1 = bus.req1_valid && (!bus.req0_valid || !lastGrant);
  end

  assign bus.req0_ready = (state == IDLE) && grant0;
  assign bus.req1_ready = (state == IDLE) && grant1;
  assign ownerReady     = owner ? bus.rsp1_ready : bus.rsp0_ready;

  always_comb begin
    stateNext     = state;
    ownerNext     = owner;
    lastGrantNext = lastGrant;
    waitCntNext   = waitCnt;
    addStartNext  = 1'b0;
    addANext      = addA;
    addBNext      = addB;
    rspResultNext = rspResult;
    rspErrNext    = rspErr;
    rspValidNext  = 2'b00;
    opCountNext   = opCount;
    case (state)
      IDLE: begin
        if (grant0 || grant1) begin
          stateNext    = ISSUE;
          ownerNext    = grant1;
          addStartNext = 1'b1;
          addANext     = grant1 ? bus.req1_a : bus.req0_a;
          addBNext     = grant1 ? bus.req1_b : bus.req0_b;
        end
      end
      ISSUE: begin
        stateNext   = WAIT;
        waitCntNext = '0;
      end
      // A completion on the last allowed cycle still beats the timeout.
      WAIT: begin
        if (bus.add_done) begin
          stateNext           = RESP;
          rspResultNext       = bus.add_result;
          rspErrNext          = 1'b0;
          rspValidNext[owner] = 1'b1;
        end else if (waitCnt == LastWait) begin
          stateNext           = RESP;
          rspResultNext       = TimeoutResult;
          rspErrNext          = 1'b1;
          rspValidNext[owner] = 1'b1;
        end else begin
          waitCntNext = waitCnt + CntW'(1);
        end
      end
      RESP: begin
        if (ownerReady) begin
          stateNext     = IDLE;
          lastGrantNext = owner;
          opCountNext   = opCount + OpCntW'(1);
        end else begin
          rspValidNext[owner] = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
    busyNext = (stateNext != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      lastGrant <= 1'b1;
      waitCnt   <= '0;
      addStart  <= 1'b0;
      addA      <= '0;
      addB      <= '0;
      rspResult <= '0;
      rspErr    <= 1'b0;
      rspValid  <= 2'b00;
      busyQ     <= 1'b0;
      opCount   <= '0;
    end else begin
      state     <= stateNext;
      owner     <= ownerNext;
      lastGrant <= lastGrantNext;
      waitCnt   <= waitCntNext;
      addStart  <= addStartNext;
      addA      <= addANext;
      addB      <= addBNext;
      rspResult <= rspResultNext;
      rspErr    <= rspErrNext;
      rspValid  <= rspValidNext;
      busyQ     <= busyNext;
      opCount   <= opCountNext;
    end
  end

  assign bus.add_start  = addStart;
  assign bus.add_a      = addA;
  assign bus.add_b      = addB;
  assign bus.rsp_result = rspResult;
  assign bus.rsp_err    = rspErr;
  assign bus.rsp0_valid = rspValid[0];
  assign bus.rsp1_valid = rspValid[1];
  assign bus.busy       = busyQ;
  assign bus.op_count   = opCount;
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: the bench plays both requesters and the shared adder,
// and predicts grants, latencies, results and the op counter from plain rules.
module tb_fp_add_arbiter;
  localparam int unsigned TIMEOUT   = 16;
  localparam logic [31:0] TimeoutRes = 32'h7FFF_FFFF;

  typedef struct packed {
    bit          hung;
    int          grant;
    bit          bothReady;
    int          acceptCyc;
    int          starts;
    int          startCyc;
    logic [31:0] addA;
    logic [31:0] addB;
    bit          operandsHeld;
    int          rspCyc;
    logic [1:0]  rspMask;
    logic [31:0] result;
    logic        err;
    bit          stable;
    bit          readyLeak;
    logic [15:0] opCount;
    logic        validAfter;
    logic        busyAfter;
  } obsT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  bit          mLastGrant = 1'b1;
  logic [15:0] mOpCount = 16'h0;

  fp_add_arbiter_if bus();

  fp_add_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference rules: single valid wins; on contention the one not served last wins.
  function automatic int exp_grant(input bit v0, input bit v1);
    if (v0 && v1) return mLastGrant ? 0 : 1;
    return v1 ? 1 : 0;
  endfunction

  // Cycles from add_start to rsp_valid, for a done arriving d cycles after add_start.
  function automatic int exp_latency(input int d);
    if (d >= 1 && d <= int'(TIMEOUT)) return d + 1;
    return int'(TIMEOUT) + 1;
  endfunction

  function automatic void model_commit(input int g);
    mLastGrant = (g == 1);
    mOpCount   = mOpCount + 16'd1;
  endfunction

  // One transaction: requesters, adder responder and response handshake; records what it saw.
  task automatic do_op(input bit v0, input bit v1,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input int doneDelay, input logic [31:0] sum, input int rspDelay,
                       input bit holdValid, input bit noise, output obsT o);
    int s;
    bit accepted;
    o = '0;
    bus.req0_valid = v0; bus.req1_valid = v1;
    bus.req0_a = a0; bus.req0_b = b0; bus.req1_a = a1; bus.req1_b = b1;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0; bus.add_done = 1'b0;
    #1;
    accepted = 1'b0;
    for (int g = 0; g < 20 && !accepted; g++) begin
      if (bus.req0_ready || bus.req1_ready) begin
        accepted    = 1'b1;
        o.grant     = bus.req1_ready ? 1 : 0;
        o.bothReady = bus.req0_ready && bus.req1_ready;
        o.acceptCyc = cyc;
      end
      tick();
    end
    if (!accepted) begin o.hung = 1'b1; return; end
    if (!holdValid) begin bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; end
    s = -1;
    o.operandsHeld = 1'b1;
    for (int g = 0; g < 60; g++) begin
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        o.rspCyc  = cyc;
        o.rspMask = {bus.rsp1_valid, bus.rsp0_valid};
        o.result  = bus.rsp_result;
        o.err     = bus.rsp_err;
        break;
      end
      if (bus.req0_ready || bus.req1_ready) o.readyLeak = 1'b1;
      if (bus.add_start) begin
        o.starts = o.starts + 1;
        if (s < 0) begin s = cyc; o.startCyc = cyc; o.addA = bus.add_a; o.addB = bus.add_b; end
      end else if (s >= 0 && (bus.add_a !== o.addA || bus.add_b !== o.addB)) begin
        o.operandsHeld = 1'b0;
      end
      bus.add_done   = (s >= 0) && ((noise && cyc == s) || (doneDelay > 0 && cyc == s + doneDelay));
      bus.add_result = (noise && cyc == s) ? ~sum : sum;
      tick();
    end
    bus.add_done = 1'b0;
    if (o.rspMask == 2'b00) begin o.hung = 1'b1; return; end
    o.stable = 1'b1;
    for (int i = 0; i < rspDelay; i++) begin
      bus.add_done = noise; bus.add_result = ~sum;
      tick();
      if ({bus.rsp1_valid, bus.rsp0_valid} !== o.rspMask || bus.rsp_result !== o.result ||
          bus.rsp_err !== o.err || bus.busy !== 1'b1) o.stable = 1'b0;
      if (bus.req0_ready || bus.req1_ready) o.readyLeak = 1'b1;
    end
    bus.add_done = 1'b0;
    if (o.rspMask[1]) bus.rsp1_ready = 1'b1; else bus.rsp0_ready = 1'b1;
    tick();
    o.opCount    = bus.op_count;
    o.validAfter = bus.rsp0_valid || bus.rsp1_valid;
    o.busyAfter  = bus.busy;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (bus.add_start !== 1'b0) begin errors++; $display("FAIL reset_add_start got=%h exp=0", bus.add_start); end
    checks++; if (bus.rsp0_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp0_valid got=%h exp=0", bus.rsp0_valid); end
    checks++; if (bus.rsp1_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp1_valid got=%h exp=0", bus.rsp1_valid); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%h exp=0", bus.rsp_err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%h exp=0", bus.busy); end
    checks++; if (bus.op_count !== 16'h0) begin errors++; $display("FAIL reset_op_count got=%h exp=0", bus.op_count); end
    checks++; if (bus.rsp_result !== 32'h0) begin errors++; $display("FAIL reset_rsp_result got=%h exp=0", bus.rsp_result); end
    checks++; if (bus.add_a !== 32'h0) begin errors++; $display("FAIL reset_add_a got=%h exp=0", bus.add_a); end
    checks++; if (bus.add_b !== 32'h0) begin errors++; $display("FAIL reset_add_b got=%h exp=0", bus.add_b); end
    reset = 1'b0;
    mLastGrant = 1'b1; mOpCount = 16'h0;
  endtask

  task automatic test_single_op();
    obsT o;
    do_op(1'b1, 1'b0, 32'h3F80_0000, 32'h4000_0000, 32'h0, 32'h0, 2, 32'h4040_0000, 0, 1'b0, 1'b0, o);
    checks++; if (o.hung !== 1'b0) begin errors++; $display("FAIL single_hung got=%0d exp=0", o.hung); end
    checks++; if (o.grant !== 0) begin errors++; $display("FAIL single_grant got=%0d exp=0", o.grant); end
    checks++; if (o.startCyc !== o.acceptCyc + 1) begin errors++; $display("FAIL single_start_cyc got=%0d exp=%0d", o.startCyc, o.acceptCyc + 1); end
    checks++; if (o.starts !== 1) begin errors++; $display("FAIL single_start_width got=%0d exp=1", o.starts); end
    checks++; if (o.addA !== 32'h3F80_0000) begin errors++; $display("FAIL single_add_a got=%h exp=3f800000", o.addA); end
    checks++; if (o.addB !== 32'h4000_0000) begin errors++; $display("FAIL single_add_b got=%h exp=40000000", o.addB); end
    checks++; if (o.rspCyc !== o.startCyc + 3) begin errors++; $display("FAIL single_rsp_cyc got=%0d exp=%0d", o.rspCyc, o.startCyc + 3); end
    checks++; if (o.rspMask !== 2'b01) begin errors++; $display("FAIL single_rsp_owner got=%b exp=01", o.rspMask); end
    checks++; if (o.result !== 32'h4040_0000) begin errors++; $display("FAIL single_result got=%h exp=40400000", o.result); end
    checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL single_err got=%h exp=0", o.err); end
    checks++; if (o.opCount !== 16'd1) begin errors++; $display("FAIL single_op_count got=%h exp=1", o.opCount); end
    checks++; if (o.busyAfter !== 1'b0 || o.validAfter !== 1'b0) begin errors++; $display("FAIL single_idle_after got=%b%b exp=00", o.busyAfter, o.validAfter); end
    model_commit(o.grant);
  endtask

  task automatic test_back_to_back();
    obsT o1;
    obsT o2;
    logic [31:0] s1;
    logic [31:0] s2;
    s1 = $urandom(); s2 = $urandom();
    do_op(1'b0, 1'b1, 32'h0, 32'h0, $urandom(), $urandom(), 1, s1, 0, 1'b0, 1'b0, o1);
    checks++; if (o1.grant !== exp_grant(1'b0, 1'b1)) begin errors++; $display("FAIL b2b_grant1 got=%0d exp=1", o1.grant); end
    checks++; if (o1.rspCyc !== o1.acceptCyc + 3) begin errors++; $display("FAIL b2b_min_latency got=%0d exp=%0d", o1.rspCyc, o1.acceptCyc + 3); end
    checks++; if (o1.result !== s1 || o1.rspMask !== 2'b10) begin errors++; $display("FAIL b2b_result1 got=%h/%b exp=%h/10", o1.result, o1.rspMask, s1); end
    model_commit(o1.grant);
    do_op(1'b1, 1'b0, $urandom(), $urandom(), 32'h0, 32'h0, 1, s2, 0, 1'b0, 1'b0, o2);
    checks++; if (o2.acceptCyc !== o1.rspCyc + 1) begin errors++; $display("FAIL b2b_accept_cyc got=%0d exp=%0d", o2.acceptCyc, o1.rspCyc + 1); end
    checks++; if (o2.result !== s2 || o2.rspMask !== 2'b01) begin errors++; $display("FAIL b2b_result2 got=%h/%b exp=%h/01", o2.result, o2.rspMask, s2); end
    checks++; if (o2.opCount !== mOpCount + 16'd1) begin errors++; $display("FAIL b2b_op_count got=%h exp=%h", o2.opCount, mOpCount + 16'd1); end
    model_commit(o2.grant);
  endtask

  task automatic test_timeout();
    obsT o;
    logic [31:0] s;
    do_op(1'b0, 1'b1, 32'h0, 32'h0, $urandom(), $urandom(), -1, 32'h0, 0, 1'b0, 1'b0, o);
    checks++; if (o.hung !== 1'b0) begin errors++; $display("FAIL timeout_hung got=%0d exp=0", o.hung); end
    checks++; if (o.rspCyc !== o.startCyc + int'(TIMEOUT) + 1) begin errors++; $display("FAIL timeout_rsp_cyc got=%0d exp=%0d", o.rspCyc, o.startCyc + int'(TIMEOUT) + 1); end
    checks++; if (o.rspMask !== 2'b10) begin errors++; $display("FAIL timeout_owner got=%b exp=10", o.rspMask); end
    checks++; if (o.result !== TimeoutRes) begin errors++; $display("FAIL timeout_result got=%h exp=%h", o.result, TimeoutRes); end
    checks++; if (o.err !== 1'b1) begin errors++; $display("FAIL timeout_err got=%h exp=1", o.err); end
    checks++; if (o.opCount !== mOpCount + 16'd1) begin errors++; $display("FAIL timeout_op_count got=%h exp=%h", o.opCount, mOpCount + 16'd1); end
    model_commit(o.grant);
    // A late completion while idle must leave everything untouched.
    for (int i = 0; i < 3; i++) begin
      bus.add_done = 1'b1; bus.add_result = $urandom();
      tick();
      checks++; if ({bus.busy, bus.rsp1_valid, bus.rsp0_valid} !== 3'b000) begin errors++; $display("FAIL late_done_idle got=%b exp=000", {bus.busy, bus.rsp1_valid, bus.rsp0_valid}); end
      checks++; if (bus.rsp_result !== TimeoutRes || bus.rsp_err !== 1'b1 || bus.op_count !== mOpCount) begin errors++; $display("FAIL late_done_state got=%h/%h/%h exp=%h/1/%h", bus.rsp_result, bus.rsp_err, bus.op_count, TimeoutRes, mOpCount); end
    end
    bus.add_done = 1'b0;
    // Completion on the last allowed wait cycle still succeeds and clears the error flag.
    s = $urandom();
    do_op(1'b1, 1'b0, $urandom(), $urandom(), 32'h0, 32'h0, int'(TIMEOUT), s, 0, 1'b0, 1'b0, o);
    checks++; if (o.result !== s || o.err !== 1'b0) begin errors++; $display("FAIL edge_done_result got=%h/%h exp=%h/0", o.result, o.err, s); end
    checks++; if (o.rspCyc !== o.startCyc + int'(TIMEOUT) + 1) begin errors++; $display("FAIL edge_done_cyc got=%0d exp=%0d", o.rspCyc, o.startCyc + int'(TIMEOUT) + 1); end
    model_commit(o.grant);
  endtask

  task automatic test_backpressure();
    obsT o;
    logic [31:0] s;
    s = $urandom();
    do_op(1'b1, 1'b0, $urandom(), $urandom(), 32'h0, 32'h0, 2, s, 0, 1'b0, 1'b0, o);
    checks++; if (o.grant !== exp_grant(1'b1, 1'b0) || o.result !== s) begin errors++; $display("FAIL bp_setup got=%0d/%h exp=0/%h", o.grant, o.result, s); end
    model_commit(o.grant);
    s = $urandom();
    do_op(1'b1, 1'b1, $urandom(), $urandom(), $urandom(), $urandom(), 3, s, 10, 1'b1, 1'b1, o);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    checks++; if (o.grant !== exp_grant(1'b1, 1'b1)) begin errors++; $display("FAIL bp_grant got=%0d exp=%0d", o.grant, exp_grant(1'b1, 1'b1)); end
    checks++; if (o.stable !== 1'b1) begin errors++; $display("FAIL bp_stable got=%0d exp=1", o.stable); end
    checks++; if (o.readyLeak !== 1'b0) begin errors++; $display("FAIL bp_ready_leak got=%0d exp=0", o.readyLeak); end
    checks++; if (o.rspMask !== 2'b10 || o.result !== s || o.err !== 1'b0) begin errors++; $display("FAIL bp_result got=%b/%h/%h exp=10/%h/0", o.rspMask, o.result, o.err, s); end
    checks++; if (o.opCount !== mOpCount + 16'd1) begin errors++; $display("FAIL bp_op_count got=%h exp=%h", o.opCount, mOpCount + 16'd1); end
    model_commit(o.grant);
  endtask

  task automatic test_reset_mid_wait();
    bus.req1_a = $urandom(); bus.req1_b = $urandom(); bus.req1_valid = 1'b1;
    #1;
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_accept got=%h exp=1", bus.req1_ready); end
    tick(); bus.req1_valid = 1'b0;
    tick(); tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy got=%h exp=1", bus.busy); end
    reset = 1'b1; bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({bus.add_start, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err, bus.busy} !== 5'b0) begin errors++; $display("FAIL rst_mid_flags got=%b exp=00000", {bus.add_start, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err, bus.busy}); end
    checks++; if ({bus.op_count, bus.rsp_result, bus.add_a, bus.add_b} !== 112'h0) begin errors++; $display("FAIL rst_mid_data got=%h/%h/%h/%h exp=0", bus.op_count, bus.rsp_result, bus.add_a, bus.add_b); end
    mLastGrant = 1'b1; mOpCount = 16'h0;
    checks++; if ({bus.req1_ready, bus.req0_ready} !== (exp_grant(1'b1, 1'b1) == 0 ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rst_mid_first_grant got=%b exp=01", {bus.req1_ready, bus.req0_ready}); end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.add_done = 1'b1; bus.add_result = $urandom();
    tick();
    bus.add_done = 1'b0;
    checks++; if ({bus.busy, bus.rsp1_valid, bus.rsp0_valid} !== 3'b000 || bus.rsp_result !== 32'h0 || bus.op_count !== 16'h0) begin errors++; $display("FAIL rst_mid_stale_done got=%b/%h/%h exp=000/0/0", {bus.busy, bus.rsp1_valid, bus.rsp0_valid}, bus.rsp_result, bus.op_count); end
  endtask

  task automatic test_contention(input int n);
    obsT o;
    logic [31:0] a0, b0, a1, b1, s;
    int eg;
    for (int i = 0; i < n; i++) begin
      a0 = $urandom(); b0 = $urandom(); a1 = $urandom(); b1 = $urandom(); s = $urandom();
      eg = exp_grant(1'b1, 1'b1);
      do_op(1'b1, 1'b1, a0, b0, a1, b1, int'($urandom_range(1, 4)), s, 0, 1'b1, 1'b0, o);
      checks++; if (o.grant !== eg || o.bothReady !== 1'b0) begin errors++; $display("FAIL cont_grant[%0d] got=%0d/%0d exp=%0d/0", i, o.grant, o.bothReady, eg); end
      checks++; if (o.addA !== (eg == 1 ? a1 : a0) || o.addB !== (eg == 1 ? b1 : b0)) begin errors++; $display("FAIL cont_operands[%0d] got=%h/%h exp=%h/%h", i, o.addA, o.addB, eg == 1 ? a1 : a0, eg == 1 ? b1 : b0); end
      checks++; if (o.starts !== 1 || o.readyLeak !== 1'b0) begin errors++; $display("FAIL cont_start_leak[%0d] got=%0d/%0d exp=1/0", i, o.starts, o.readyLeak); end
      checks++; if (o.rspMask !== (eg == 1 ? 2'b10 : 2'b01) || o.result !== s) begin errors++; $display("FAIL cont_result[%0d] got=%b/%h exp=%b/%h", i, o.rspMask, o.result, eg == 1 ? 2'b10 : 2'b01, s); end
      checks++; if (o.opCount !== mOpCount + 16'd1) begin errors++; $display("FAIL cont_op_count[%0d] got=%h exp=%h", i, o.opCount, mOpCount + 16'd1); end
      model_commit(o.grant);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
  endtask

  task automatic test_random(input int n);
    obsT o;
    logic [31:0] a0, b0, a1, b1, s, expRes;
    int v, d, eg;
    bit ok;
    for (int i = 0; i < n; i++) begin
      v = int'($urandom_range(1, 3));
      a0 = $urandom(); b0 = $urandom(); a1 = $urandom(); b1 = $urandom(); s = $urandom();
      if ($urandom_range(0, 5) == 0) d = int'(TIMEOUT) + int'($urandom_range(0, 2));
      else d = int'($urandom_range(1, 5));
      eg = exp_grant(v[0], v[1]);
      ok = (d <= int'(TIMEOUT));
      expRes = ok ? s : TimeoutRes;
      do_op(v[0], v[1], a0, b0, a1, b1, d, s, int'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)), o);
      checks++; if (o.hung !== 1'b0 || o.grant !== eg) begin errors++; $display("FAIL rnd_grant[%0d] got=%0d hung=%0d exp=%0d", i, o.grant, o.hung, eg); end
      checks++; if (o.addA !== (eg == 1 ? a1 : a0) || o.addB !== (eg == 1 ? b1 : b0) || o.operandsHeld !== 1'b1) begin errors++; $display("FAIL rnd_operands[%0d] got=%h/%h held=%0d", i, o.addA, o.addB, o.operandsHeld); end
      checks++; if (o.startCyc !== o.acceptCyc + 1 || o.starts !== 1) begin errors++; $display("FAIL rnd_start[%0d] got=%0d/%0d exp=%0d/1", i, o.startCyc, o.starts, o.acceptCyc + 1); end
      checks++; if (o.rspCyc !== o.startCyc + exp_latency(d)) begin errors++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", i, o.rspCyc - o.startCyc, exp_latency(d)); end
      checks++; if (o.rspMask !== (eg == 1 ? 2'b10 : 2'b01) || o.result !== expRes || o.err !== !ok) begin errors++; $display("FAIL rnd_result[%0d] got=%b/%h/%h exp=%b/%h/%h", i, o.rspMask, o.result, o.err, eg == 1 ? 2'b10 : 2'b01, expRes, !ok); end
      checks++; if (o.stable !== 1'b1 || o.opCount !== mOpCount + 16'd1) begin errors++; $display("FAIL rnd_hold_count[%0d] got=%0d/%h exp=1/%h", i, o.stable, o.opCount, mOpCount + 16'd1); end
      model_commit(o.grant);
    end
  endtask

  task automatic test_wrap();
    obsT o;
    force dut.opCount = 16'hFFFF;
    tick();
    release dut.opCount;
    mOpCount = 16'hFFFF;
    do_op(1'b1, 1'b0, $urandom(), $urandom(), 32'h0, 32'h0, 2, $urandom(), 0, 1'b0, 1'b0, o);
    checks++; if (o.opCount !== 16'h0000) begin errors++; $display("FAIL wrap_op_count got=%h exp=0000", o.opCount); end
    model_commit(o.grant);
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    bus.add_done = 1'b0; bus.add_result = '0;
    test_reset();
    test_single_op();
    test_back_to_back();
    test_timeout();
    test_backpressure();
    test_reset_mid_wait();
    test_contention(4);
    test_random(40);
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
